// File: rtl/clkgen_wb_master_if.sv
// -----------------------------------------------------------------------------
// clkgen_wb_master_if
// Purpose : Bundles the command/response handshake and the Wishbone-style bus
//           signals of clkgen_wb_master into one interface.
// Signals : i_cmd_valid, i_cmd_we, i_cmd_dat   command offered to the master
//           o_cmd_ready                         master can accept a command
//           o_rsp_valid, o_rsp_dat, o_rsp_err   one-cycle completion report
//           o_busy                              master is not idle
//           o_wb_adr, o_wb_dat, o_wb_we,
//           o_wb_cyc                            bus request towards responder
//           i_wb_rdt, i_wb_ack                  responder read data / ack
// Modports: master -- the clkgen_wb_master block itself
//           slave  -- the environment (command source and bus responder)
// The i_/o_ prefixes are written from the point of view of the master block.
// -----------------------------------------------------------------------------
interface clkgen_wb_master_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [31:0] i_cmd_dat;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_dat;
    logic        o_rsp_err;
    logic        o_busy;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_dat, i_wb_rdt, i_wb_ack,
        output o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_err, o_busy,
               o_wb_adr, o_wb_dat, o_wb_we, o_wb_cyc
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_dat, i_wb_rdt, i_wb_ack,
        input  o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_err, o_busy,
               o_wb_adr, o_wb_dat, o_wb_we, o_wb_cyc
    );
endinterface

// File: rtl/clkgen_wb_master.sv
// -----------------------------------------------------------------------------
// clkgen_wb_master
// Purpose : Single-outstanding bus master. Accepts one read/write command,
//           raises o_wb_cyc towards a fixed address, waits for an acknowledge
//           with a per-attempt timeout, retries a bounded number of times
//           after one idle gap cycle, and reports completion with a one-cycle
//           response pulse (o_rsp_err set when every attempt timed out).
// Params  : TIMEOUT_CYCLES  cycles of cyc without ack before an attempt is
//                           abandoned (1..65535)
//           MAX_RETRY       re-attempts after the first timeout (0..7)
//           TGT_ADR         constant bus address
// Ports   : i_clk    sole clock, rising edge
//           i_rst_n  asynchronous active-low reset
//           bus      clkgen_wb_master_if.master (command, response, bus)
// -----------------------------------------------------------------------------
module clkgen_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 2,
    parameter logic [31:0] TGT_ADR        = 32'h0000_0000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    clkgen_wb_master_if.master        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Last count value seen before the timeout fires; reaching it with no ack
    // means the attempt has had TIMEOUT_CYCLES cycles of cyc high.
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  RETRY_LIM = 3'(MAX_RETRY);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_retry;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;
    logic        r_busy;
    logic        r_wb_cyc;
    logic [31:0] r_wb_dat;
    logic        r_wb_we;

    // Control FSM; every output is a register updated together with the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 16'd0;
            r_retry     <= 3'd0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_wb_cyc    <= 1'b0;
            r_wb_dat    <= 32'd0;
            r_wb_we     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_cmd_valid && r_cmd_ready) begin
                        r_wb_we     <= bus.i_cmd_we;
                        r_wb_dat    <= bus.i_cmd_dat;
                        r_cnt       <= 16'd0;
                        r_retry     <= 3'd0;
                        r_rsp_dat   <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_wb_cyc    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_REQ;
                    end else begin
                        // Also raises ready on the first edge after reset.
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Ack is tested first so it wins over a coinciding timeout.
                    if (bus.i_wb_ack) begin
                        r_rsp_dat   <= r_wb_we ? 32'd0 : bus.i_wb_rdt;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_wb_cyc    <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        // r_cnt <= TIMEOUT_CYCLES, which fits in 16 bits.
                        r_cnt       <= r_cnt + 16'd1;
                        r_wb_cyc    <= 1'b0;
                        r_state     <= ST_GAP;
                    end else begin
                        r_cnt       <= r_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (r_retry < RETRY_LIM) begin
                        r_retry     <= r_retry + 3'd1;
                        r_cnt       <= 16'd0;
                        r_wb_cyc    <= 1'b1;
                        r_state     <= ST_REQ;
                    end else begin
                        r_rsp_dat   <= 32'd0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rsp_dat   <= 32'd0;
                    r_rsp_err   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_wb_cyc    <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_cmd_ready = r_cmd_ready;
    assign bus.o_rsp_valid = r_rsp_valid;
    assign bus.o_rsp_dat   = r_rsp_dat;
    assign bus.o_rsp_err   = r_rsp_err;
    assign bus.o_busy      = r_busy;
    assign bus.o_wb_adr    = TGT_ADR;
    assign bus.o_wb_dat    = r_wb_dat;
    assign bus.o_wb_we     = r_wb_we;
    assign bus.o_wb_cyc    = r_wb_cyc;

endmodule

// File: tb/tb_clkgen_wb_master.sv
module tb_clkgen_wb_master;

    localparam logic [31:0] ADR = 32'hA5A5_0000;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    clkgen_wb_master_if bus();

    clkgen_wb_master #(
        .TIMEOUT_CYCLES(4),
        .MAX_RETRY(2),
        .TGT_ADR(ADR)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({bus.o_wb_cyc, bus.o_cmd_ready, bus.o_busy, bus.o_rsp_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs cyc/rdy/busy/vld=%b expected 0000",
                     {bus.o_wb_cyc, bus.o_cmd_ready, bus.o_busy, bus.o_rsp_valid});
        end
        checks++;
        if (bus.o_wb_adr !== ADR) begin
            failures++;
            $display("FAIL reset_adr got=%h expected=%h", bus.o_wb_adr, ADR);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release rdy=%b busy=%b expected rdy=1 busy=0",
                     bus.o_cmd_ready, bus.o_busy);
        end
    endtask

    task automatic test_write;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_we    = 1'b1;
        bus.i_cmd_dat   = 32'h0000_0001;
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_dat   = 32'hFFFF_FFFF;
        checks++;
        if ({bus.o_wb_cyc, bus.o_wb_we, bus.o_busy, bus.o_cmd_ready} !== 4'b1110 ||
            bus.o_wb_dat !== 32'h1) begin
            failures++;
            $display("FAIL write_req cyc/we/busy/rdy=%b dat=%h expected 1110 dat=1",
                     {bus.o_wb_cyc, bus.o_wb_we, bus.o_busy, bus.o_cmd_ready}, bus.o_wb_dat);
        end
        tick();
        checks++;
        if (bus.o_wb_cyc !== 1'b1 || bus.o_wb_dat !== 32'h1 || bus.o_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_hold cyc=%b dat=%h vld=%b expected cyc=1 dat=1 vld=0",
                     bus.o_wb_cyc, bus.o_wb_dat, bus.o_rsp_valid);
        end
        bus.i_wb_ack = 1'b1;
        tick();
        bus.i_wb_ack = 1'b0;
        checks++;
        if ({bus.o_wb_cyc, bus.o_rsp_valid, bus.o_rsp_err} !== 3'b010 || bus.o_rsp_dat !== 32'h0) begin
            failures++;
            $display("FAIL write_rsp cyc/vld/err=%b dat=%h expected 010 dat=0",
                     {bus.o_wb_cyc, bus.o_rsp_valid, bus.o_rsp_err}, bus.o_rsp_dat);
        end
        tick();
        checks++;
        if ({bus.o_rsp_valid, bus.o_wb_cyc, bus.o_busy, bus.o_cmd_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL write_idle vld/cyc/busy/rdy=%b expected 0001",
                     {bus.o_rsp_valid, bus.o_wb_cyc, bus.o_busy, bus.o_cmd_ready});
        end
    endtask

    task automatic test_read;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_we    = 1'b0;
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_wb_rdt    = 32'hDEAD_BEEF;
        tick();
        bus.i_wb_rdt    = 32'h0000_0001;
        bus.i_wb_ack    = 1'b1;
        tick();
        bus.i_wb_ack    = 1'b0;
        bus.i_wb_rdt    = 32'h0;
        checks++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_err !== 1'b0 || bus.o_rsp_dat !== 32'h1) begin
            failures++;
            $display("FAIL read_rsp vld=%b err=%b dat=%h expected vld=1 err=0 dat=00000001",
                     bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_dat);
        end
        tick();
    endtask

    task automatic test_timeout;
        int bad_high = 0;
        int bad_gap  = 0;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_we    = 1'b0;
        bus.i_wb_rdt    = 32'h0000_1234;
        tick();
        bus.i_cmd_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.o_wb_cyc !== 1'b1) bad_high++;
                tick();
            end
            if (bus.o_wb_cyc !== 1'b0 || bus.o_rsp_valid !== 1'b0) bad_gap++;
            tick();
        end
        checks++;
        if (bad_high != 0) begin
            failures++;
            $display("FAIL timeout_bursts cyc-low samples inside bursts=%0d expected 0", bad_high);
        end
        checks++;
        if (bad_gap != 0) begin
            failures++;
            $display("FAIL timeout_gaps bad gap samples=%0d expected 0", bad_gap);
        end
        checks++;
        if ({bus.o_rsp_valid, bus.o_rsp_err, bus.o_wb_cyc} !== 3'b110 || bus.o_rsp_dat !== 32'h0) begin
            failures++;
            $display("FAIL timeout_rsp vld/err/cyc=%b dat=%h expected 110 dat=0",
                     {bus.o_rsp_valid, bus.o_rsp_err, bus.o_wb_cyc}, bus.o_rsp_dat);
        end
        bus.i_wb_rdt = 32'h0;
        tick();
    endtask

    task automatic test_stray_ack;
        bus.i_wb_ack = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.o_cmd_ready, bus.o_busy, bus.o_wb_cyc, bus.o_rsp_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL stray_ack rdy/busy/cyc/vld=%b expected 1000",
                     {bus.o_cmd_ready, bus.o_busy, bus.o_wb_cyc, bus.o_rsp_valid});
        end
        bus.i_wb_ack = 1'b0;
    endtask

    task automatic test_ack_on_timeout;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_we    = 1'b0;
        tick();
        bus.i_cmd_valid = 1'b0;
        repeat (3) tick();
        bus.i_wb_rdt = 32'h0000_0055;
        bus.i_wb_ack = 1'b1;
        tick();
        bus.i_wb_ack = 1'b0;
        bus.i_wb_rdt = 32'h0;
        checks++;
        if ({bus.o_rsp_valid, bus.o_rsp_err, bus.o_wb_cyc} !== 3'b100 || bus.o_rsp_dat !== 32'h55) begin
            failures++;
            $display("FAIL ack_on_timeout vld/err/cyc=%b dat=%h expected 100 dat=00000055",
                     {bus.o_rsp_valid, bus.o_rsp_err, bus.o_wb_cyc}, bus.o_rsp_dat);
        end
        tick();
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ack_on_timeout_idle busy=%b rdy=%b expected busy=0 rdy=1",
                     bus.o_busy, bus.o_cmd_ready);
        end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_we    = 1'b1;
        bus.i_cmd_dat   = 32'h0000_0007;
        tick();
        bus.i_cmd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_wb_cyc, bus.o_busy, bus.o_cmd_ready} !== 3'b000 || bus.o_wb_dat !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_async cyc/busy/rdy=%b dat=%h expected 000 dat=0",
                     {bus.o_wb_cyc, bus.o_busy, bus.o_cmd_ready}, bus.o_wb_dat);
        end
        repeat (2) begin
            tick();
            if (bus.o_rsp_valid !== 1'b0) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        if (bus.o_rsp_valid !== 1'b0) pulses++;
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_mid_no_rsp pulses=%0d expected 0", pulses);
        end
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_we    = 1'b1;
        bus.i_cmd_dat   = 32'h0000_0009;
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_wb_ack    = 1'b1;
        tick();
        bus.i_wb_ack    = 1'b0;
        checks++;
        if ({bus.o_rsp_valid, bus.o_rsp_err} !== 2'b10) begin
            failures++;
            $display("FAIL reset_mid_recover vld/err=%b expected 10",
                     {bus.o_rsp_valid, bus.o_rsp_err});
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int          rsp_cnt  = 0;
        int          rises    = 0;
        int          gap      = 0;
        logic        prev_cyc = 1'b0;
        logic [31:0] got0     = 32'h0;
        logic [31:0] got1     = 32'h0;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_we    = 1'b0;
        bus.i_wb_ack    = 1'b0;
        for (int i = 0; i < 40 && rsp_cnt < 2; i++) begin
            bus.i_wb_rdt = (rsp_cnt == 0) ? 32'h0000_0011 : 32'h0000_0022;
            tick();
            if (bus.o_wb_cyc && !prev_cyc) begin
                rises++;
                if (rises == 2) bus.i_cmd_valid = 1'b0;
            end
            if (!bus.o_wb_cyc && rises == 1) gap++;
            if (bus.o_rsp_valid) begin
                if (rsp_cnt == 0) got0 = bus.o_rsp_dat;
                if (rsp_cnt == 1) got1 = bus.o_rsp_dat;
                rsp_cnt++;
            end
            bus.i_wb_ack = bus.o_wb_cyc;
            prev_cyc     = bus.o_wb_cyc;
        end
        bus.i_cmd_valid = 1'b0;
        bus.i_wb_ack    = 1'b0;
        checks++;
        if (rsp_cnt != 2 || rises != 2) begin
            failures++;
            $display("FAIL b2b_count rsp=%0d bursts=%0d expected rsp=2 bursts=2", rsp_cnt, rises);
        end
        checks++;
        if (got0 !== 32'h11 || got1 !== 32'h22) begin
            failures++;
            $display("FAIL b2b_order first=%h second=%h expected 00000011 00000022", got0, got1);
        end
        checks++;
        if (gap < 1) begin
            failures++;
            $display("FAIL b2b_gap cyc-low cycles=%0d expected >=1", gap);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_we    = 1'b0;
        bus.i_cmd_dat   = 32'h0;
        bus.i_wb_rdt    = 32'h0;
        bus.i_wb_ack    = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_stray_ack();
        test_ack_on_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
